// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, imem request/grant/response handshake,
// and an in-order instruction buffer toward the decoder with flush on redirect.
package pkg_config;
  parameter int INST_WIDTH = 32;
endpackage

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          INST_WIDTH = pkg_config::INST_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [31:0]           imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [31:0]           inst_pc_o,
  input  logic                  inst_ready_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]           pc_r;
  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [PW-1:0]         fill_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         pending_r;
  logic [CW-1:0]         drop_cnt_r;
  logic [31:0]           ent_pc_r   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] ent_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_filled_r;

  logic          issue_s;
  logic          pop_s;
  logic          fill_s;
  logic          drop_s;
  logic          consumed_s;
  logic [CW-1:0] redirect_drop_s;
  logic          unused_s;

  // The two low redirect bits are forced to zero, so they never reach the PC.
  assign unused_s = ^redirect_pc_i[1:0];

  // Head entry and PC are taken straight from registers; no bypass from imem data.
  assign imem_addr_o = pc_r;
  assign inst_o      = ent_data_r[head_r];
  assign inst_pc_o   = ent_pc_r[head_r];

  // Handshake qualification and per-cycle event decode
  always_comb begin
    imem_req_o      = 1'b0;
    inst_valid_o    = 1'b0;
    if (rst_i) begin
      imem_req_o   = 1'b0;
      inst_valid_o = 1'b0;
    end else begin
      imem_req_o   = (count_r < DEPTH_C) && !redirect_i;
      inst_valid_o = (count_r != {CW{1'b0}}) && ent_filled_r[head_r] && !redirect_i;
    end
    issue_s    = imem_req_o && imem_gnt_i;
    pop_s      = inst_valid_o && inst_ready_i;
    drop_s     = imem_rvalid_i && (drop_cnt_r != {CW{1'b0}});
    fill_s     = imem_rvalid_i && (drop_cnt_r == {CW{1'b0}}) &&
                 (pending_r != {CW{1'b0}}) && !redirect_i;
    consumed_s = imem_rvalid_i &&
                 ((drop_cnt_r != {CW{1'b0}}) || (pending_r != {CW{1'b0}}));
    // Every request still in flight becomes stale; a response landing now is one of them.
    redirect_drop_s = drop_cnt_r + pending_r - CW'(consumed_s);
  end

  // Program counter, buffer pointers and occupancy/outstanding counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_r       <= RESET_PC;
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      fill_ptr_r <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      pending_r  <= {CW{1'b0}};
      drop_cnt_r <= {CW{1'b0}};
    end else if (redirect_i) begin
      pc_r       <= {redirect_pc_i[31:2], 2'b00};
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      fill_ptr_r <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      pending_r  <= {CW{1'b0}};
      drop_cnt_r <= redirect_drop_s;
    end else begin
      if (issue_s) begin
        pc_r   <= pc_r + 32'd4;
        tail_r <= tail_r + PW'(1'b1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1'b1);
      end
      if (fill_s) begin
        fill_ptr_r <= fill_ptr_r + PW'(1'b1);
      end
      count_r    <= count_r + CW'(issue_s) - CW'(pop_s);
      pending_r  <= pending_r + CW'(issue_s) - CW'(fill_s);
      drop_cnt_r <= drop_cnt_r - CW'(drop_s);
    end
  end

  // Entry storage: allocate PC on issue, write data on in-order response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_pc_r[i]   <= 32'h0000_0000;
        ent_data_r[i] <= {INST_WIDTH{1'b0}};
      end
      ent_filled_r <= {FIFO_DEPTH{1'b0}};
    end else if (redirect_i) begin
      ent_filled_r <= {FIFO_DEPTH{1'b0}};
    end else begin
      if (issue_s) begin
        ent_pc_r[tail_r]     <= pc_r;
        ent_filled_r[tail_r] <= 1'b0;
      end
      if (fill_s) begin
        ent_data_r[fill_ptr_r]   <= imem_rdata_i;
        ent_filled_r[fill_ptr_r] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory with variable latency feeds the
// DUT while a queue-based reference model predicts every output cycle by cycle.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .INST_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
  );

  typedef struct {logic [31:0] pc; logic [31:0] data; bit filled;} ent_t;
  typedef struct {logic [31:0] data; int due;} rsp_t;

  ent_t        mq[$];
  rsp_t        memq[$];
  logic [31:0] m_pc;
  int          m_drop;
  int          cyc;
  int          last_due;
  int          n_checks;
  int          n_fail;
  int          gnt_pct;
  int          rdy_pct;
  int          lat;
  bit          redir_next;
  logic [31:0] redir_pc_next;
  logic        obs_req, obs_valid, obs_issue, obs_pop, obs_rvalid;
  logic [31:0] obs_addr, obs_inst, obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    memq.delete();
    m_pc     = 32'h0000_0000;
    m_drop   = 0;
    last_due = cyc;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},     32'(imem_req_o),   32'h0);
    chk({tag, "_addr"},    imem_addr_o,       32'h0);
    chk({tag, "_valid"},   32'(inst_valid_o), 32'h0);
    chk({tag, "_inst"},    inst_o,            32'h0);
    chk({tag, "_inst_pc"}, inst_pc_o,         32'h0);
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the model.
  task automatic step();
    bit exp_req, exp_valid, found;
    int unf, due;
    @(negedge clk);
    imem_gnt_i = ($urandom_range(99) < gnt_pct);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memq[0].data;
      void'(memq.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    inst_ready_i  = ($urandom_range(99) < rdy_pct);
    redirect_i    = redir_next;
    redirect_pc_i = redir_pc_next;
    redir_next    = 1'b0;
    #1;
    exp_req   = (mq.size() < DEPTH) && !redirect_i;
    exp_valid = 1'b0;
    if (mq.size() > 0) exp_valid = mq[0].filled && !redirect_i;
    chk("req",   32'(imem_req_o),   32'(exp_req));
    chk("addr",  imem_addr_o,       m_pc);
    chk("valid", 32'(inst_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      chk("inst",    inst_o,    mq[0].data);
      chk("inst_pc", inst_pc_o, mq[0].pc);
    end
    obs_req    = imem_req_o;
    obs_addr   = imem_addr_o;
    obs_valid  = inst_valid_o;
    obs_inst   = inst_o;
    obs_pc     = inst_pc_o;
    obs_rvalid = imem_rvalid_i;
    obs_issue  = imem_req_o && imem_gnt_i;
    obs_pop    = inst_valid_o && inst_ready_i;
    if (obs_issue) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      memq.push_back('{mem_word(imem_addr_o), due});
      last_due = due;
    end
    if (redirect_i) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      m_drop = m_drop + unf - (imem_rvalid_i ? 1 : 0);
      mq.delete();
      m_pc = {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (imem_rvalid_i) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          found = 1'b0;
          for (int i = 0; i < mq.size() && !found; i++) begin
            if (!mq[i].filled) begin
              mq[i].data   = imem_rdata_i;
              mq[i].filled = 1'b1;
              found        = 1'b1;
            end
          end
          if (!found) chk("orphan_rvalid", 32'h1, 32'h0);
        end
      end
      if (exp_valid && inst_ready_i) void'(mq.pop_front());
      if (exp_req && imem_gnt_i) begin
        mq.push_back('{m_pc, 32'h0, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic redirect_step(input logic [31:0] p);
    redir_next    = 1'b1;
    redir_pc_next = p;
    step();
  endtask

  initial begin
    int          cnt, npop, k;
    bit          got;
    logic [31:0] pops [8];
    logic [31:0] resume_addr;
    logic        valid_log [10];
    logic [31:0] addr_log [10];
    logic [31:0] pc_log [10];

    n_checks = 0; n_fail = 0; cyc = 0;
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; inst_ready_i = 1'b0;
    redir_next = 1'b0; redir_pc_next = 32'h0;
    gnt_pct = 100; rdy_pct = 100; lat = 1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_i = 1'b0;

    // Straight-line fetch: always grant, 1-cycle memory, decoder always ready.
    for (int i = 0; i < 10; i++) begin
      step();
      addr_log[i] = obs_addr; valid_log[i] = obs_valid; pc_log[i] = obs_pc;
    end
    for (int i = 0; i < 8; i++) chk("line_addr", addr_log[i], 32'(4 * i));
    chk("line_valid0", 32'(valid_log[0]), 32'h0);
    chk("line_valid1", 32'(valid_log[1]), 32'h0);
    for (int i = 2; i < 10; i++) begin
      chk("line_valid", 32'(valid_log[i]), 32'h1);
      chk("line_pc", pc_log[i], 32'(4 * (i - 2)));
    end

    // Backpressure from a clean FIFO.
    rdy_pct = 0;
    redirect_step(32'h0000_0042);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt += obs_issue ? 1 : 0;
      if (obs_valid) begin
        chk("bp_hold_pc", obs_pc, 32'h40);
        chk("bp_hold_inst", obs_inst, mem_word(32'h40));
      end
    end
    chk("bp_grants", 32'(cnt), 32'd4);
    chk("bp_req_low", 32'(obs_req), 32'h0);
    rdy_pct = 100; npop = 0; got = 1'b0; resume_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs_pop && npop < 8) begin pops[npop] = obs_pc; npop++; end
      if (obs_req && !got) begin resume_addr = obs_addr; got = 1'b1; end
    end
    chk("bp_npop", 32'(npop >= 4), 32'h1);
    for (int i = 0; i < 4 && i < npop; i++) chk("bp_pop_pc", pops[i], 32'h40 + 32'(4 * i));
    chk("bp_resume", resume_addr, 32'h50);

    // Redirect with three requests outstanding to a 3-cycle memory.
    lat = 3;
    redirect_step(32'h0000_0200);
    cnt = 0;
    repeat (3) begin step(); cnt += obs_issue ? 1 : 0; end
    chk("rd_outstanding", 32'(cnt), 32'd3);
    redirect_step(32'h0000_0103);
    step();
    chk("rd_addr", obs_addr, 32'h100);
    chk("rd_req", 32'(obs_req), 32'h1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (obs_valid) begin
        got = 1'b1;
        chk("rd_first_pc", obs_pc, 32'h100);
        chk("rd_first_inst", obs_inst, mem_word(32'h100));
      end
    end
    if (!got) chk("rd_valid_timeout", 32'h0, 32'h1);

    // Drain, then redirect in a cycle that carries both a response and a pop.
    gnt_pct = 0; lat = 1;
    for (int i = 0; i < 12 && memq.size() > 0; i++) step();
    gnt_pct = 100;
    redirect_step(32'h0000_0280);
    repeat (6) step();
    redirect_step(32'h0000_0300);
    chk("co_rvalid", 32'(obs_rvalid), 32'h1);
    chk("co_valid", 32'(obs_valid), 32'h0);
    k = 0; npop = 0;
    for (int i = 1; i <= 12 && npop < 3; i++) begin
      step();
      if (i == 1) begin
        chk("co_empty", 32'(obs_valid), 32'h0);
        chk("co_addr", obs_addr, 32'h300);
      end
      if (obs_valid) begin
        if (npop == 0) k = i;
        chk("co_pc", obs_pc, 32'h300 + 32'(4 * npop));
        npop++;
      end
    end
    chk("co_latency", 32'(k), 32'd3);

    // Stalled grant keeps the request and address steady.
    gnt_pct = 0;
    redirect_step(32'h0000_0400);
    repeat (5) begin
      step();
      chk("st_req", 32'(obs_req), 32'h1);
      chk("st_addr", obs_addr, 32'h400);
    end
    gnt_pct = 100;
    step();
    chk("st_grant_addr", obs_addr, 32'h400);
    step();
    chk("st_next_addr", obs_addr, 32'h404);

    // PC wraps from the top of the address space.
    redirect_step(32'hFFFF_FFFC);
    step();
    chk("wr_addr0", obs_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_addr1", obs_addr, 32'h0000_0000);
    npop = 0;
    for (int i = 0; i < 10 && npop < 2; i++) begin
      step();
      if (obs_valid) begin
        chk("wr_pc", obs_pc, (npop == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
        npop++;
      end
    end
    chk("wr_npop", 32'(npop), 32'd2);

    // Random traffic: latency, grant rate, ready rate and redirects all vary.
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        lat = $urandom_range(3, 1); gnt_pct = $urandom_range(100, 30);
        rdy_pct = $urandom_range(100, 20);
      end
      if ($urandom_range(99) < 3) begin
        redir_next = 1'b1; redir_pc_next = $urandom;
      end
      step();
    end

    // Asynchronous reset in the middle of traffic.
    #2;
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0;
    redir_next = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    gnt_pct = 100; rdy_pct = 100; lat = 1;
    step();
    chk("midrst_first_addr", obs_addr, 32'h0);
    for (int i = 0; i < 500; i++) begin
      if (i % 50 == 0) begin
        lat = $urandom_range(3, 1); gnt_pct = $urandom_range(100, 30);
        rdy_pct = $urandom_range(100, 20);
      end
      if ($urandom_range(99) < 3) begin
        redir_next = 1'b1; redir_pc_next = $urandom;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
